// File: rtl/rs_dsp_pkg.sv
// rs_dsp_pkg
// Shared layout constants for the RS_DSP_MULT_REGOUT model: MODE_BITS field
// positions, lane and full-width operand sizes, and a coefficient extractor.
package rs_dsp_pkg;

    localparam int MODE_W       = 85;
    localparam int COEFF_W      = 20;
    localparam int COEFF0_LSB   = 65;
    localparam int COEFF1_LSB   = 45;
    localparam int COEFF2_LSB   = 25;
    localparam int COEFF3_LSB   = 5;
    localparam int FRACTURE_BIT = 0;

    // Fractured lane widths
    localparam int A_W = 10;
    localparam int B_W = 9;
    localparam int Z_W = 19;

    // Single (non-fractured) multiply widths
    localparam int FULL_A_W = 2 * A_W;
    localparam int FULL_B_W = 2 * B_W;
    localparam int FULL_Z_W = 2 * Z_W;

    function automatic logic [COEFF_W-1:0] get_coeff(input logic [MODE_W-1:0] mode,
                                                     input logic [1:0]        idx);
        logic [COEFF_W-1:0] r_coeff;
        r_coeff = '0;
        case (idx)
            2'd0:    r_coeff = mode[COEFF0_LSB +: COEFF_W];
            2'd1:    r_coeff = mode[COEFF1_LSB +: COEFF_W];
            2'd2:    r_coeff = mode[COEFF2_LSB +: COEFF_W];
            default: r_coeff = mode[COEFF3_LSB +: COEFF_W];
        endcase
        return r_coeff;
    endfunction

endpackage

// File: rtl/rs_dsp_mult_regout_model_lane_mult.sv
// rs_dsp_lane_mult
// Combinational 10x9 multiplier with per-operand signed/unsigned selection.
// Ports:
//   i_a, i_b          : lane operands (A_W, B_W bits)
//   i_unsigned_a/b    : 1 = zero-extend the operand, 0 = sign-extend
//   o_p               : product, EXT_W bits
// EXT_W is the width both operands are extended to before multiplying; with
// EXT_W = Z_W the truncated product is still exact for every operand pair.
module rs_dsp_lane_mult
    import rs_dsp_pkg::*;
#(
    parameter int EXT_W = Z_W
) (
    input  logic [A_W-1:0]   i_a,
    input  logic [B_W-1:0]   i_b,
    input  logic             i_unsigned_a,
    input  logic             i_unsigned_b,
    output logic [EXT_W-1:0] o_p
);

    logic             w_a_sign;
    logic             w_b_sign;
    logic [EXT_W-1:0] w_a_ext;
    logic [EXT_W-1:0] w_b_ext;

    assign w_a_sign = ~i_unsigned_a & i_a[A_W-1];
    assign w_b_sign = ~i_unsigned_b & i_b[B_W-1];
    assign w_a_ext  = {{(EXT_W-A_W){w_a_sign}}, i_a};
    assign w_b_ext  = {{(EXT_W-B_W){w_b_sign}}, i_b};

    // Modulo-2^EXT_W product of the extended operands equals the low bits of
    // the true signed product.
    assign o_p = w_a_ext * w_b_ext;

endmodule

// File: rtl/rs_dsp_mult_regout_model.sv
// rs_dsp_mult_regout_model
// Behavioural model of the RS_DSP_MULT_REGOUT primitive. Decodes MODE_BITS
// into four coefficients and a fracture flag, selects operand A from the
// input or a coefficient, and multiplies as two 10x9 lanes or one 20x18.
// Ports:
//   clk, lreset  : clock and synchronous active-high reset
//   a, b         : operands {A1,A2} / {B1,B2}, lane 1 in the upper half
//   feedback     : [2] selects coefficient as operand A, [1:0] its index
//   unsigned_a/b : operand signedness
//   z            : registered product {Z1,Z2} or full 38-bit product
//   dly_b        : b delayed one cycle
module rs_dsp_mult_regout_model
    import rs_dsp_pkg::*;
#(
    parameter logic [MODE_W-1:0] MODE_BITS = 85'h0,
    parameter int                INPUT_REG = 0
) (
    input  logic                clk,
    input  logic                lreset,
    input  logic [FULL_A_W-1:0] a,
    input  logic [FULL_B_W-1:0] b,
    input  logic [2:0]          feedback,
    input  logic                unsigned_a,
    input  logic                unsigned_b,
    output logic [FULL_Z_W-1:0] z,
    output logic [FULL_B_W-1:0] dly_b
);

    logic [FULL_A_W-1:0] w_a_in;
    logic [FULL_B_W-1:0] w_b_in;
    logic [2:0]          w_fb_in;
    logic                w_ua_in;
    logic                w_ub_in;
    logic [COEFF_W-1:0]  w_coeff;
    logic [FULL_A_W-1:0] w_opa;
    logic [FULL_Z_W-1:0] w_z_next;

    generate
        if (INPUT_REG != 0) begin : g_in_reg
            logic [FULL_A_W-1:0] r_a;
            logic [FULL_B_W-1:0] r_b;
            logic [2:0]          r_fb;
            logic                r_ua;
            logic                r_ub;

            // feedback travels with its operands so a coefficient switch lands
            // in the same pipeline slot.
            always_ff @(posedge clk) begin
                if (lreset) begin
                    r_a  <= '0;
                    r_b  <= '0;
                    r_fb <= '0;
                    r_ua <= 1'b0;
                    r_ub <= 1'b0;
                end else begin
                    r_a  <= a;
                    r_b  <= b;
                    r_fb <= feedback;
                    r_ua <= unsigned_a;
                    r_ub <= unsigned_b;
                end
            end

            assign w_a_in  = r_a;
            assign w_b_in  = r_b;
            assign w_fb_in = r_fb;
            assign w_ua_in = r_ua;
            assign w_ub_in = r_ub;
        end else begin : g_no_in_reg
            assign w_a_in  = a;
            assign w_b_in  = b;
            assign w_fb_in = feedback;
            assign w_ua_in = unsigned_a;
            assign w_ub_in = unsigned_b;
        end
    endgenerate

    assign w_coeff = get_coeff(MODE_BITS, w_fb_in[1:0]);
    assign w_opa   = w_fb_in[2] ? w_coeff : w_a_in;

    // The fracture flag is a parameter, so only the selected datapath is
    // elaborated. An unknown flag has no defined datapath and yields all-X.
    generate
        if (MODE_BITS[FRACTURE_BIT] === 1'b1) begin : g_frac
            logic [Z_W-1:0] w_z1;
            logic [Z_W-1:0] w_z2;

            rs_dsp_lane_mult #(.EXT_W(Z_W)) u_lane1 (
                .i_a          (w_opa[FULL_A_W-1:A_W]),
                .i_b          (w_b_in[FULL_B_W-1:B_W]),
                .i_unsigned_a (w_ua_in),
                .i_unsigned_b (w_ub_in),
                .o_p          (w_z1)
            );

            rs_dsp_lane_mult #(.EXT_W(Z_W)) u_lane2 (
                .i_a          (w_opa[A_W-1:0]),
                .i_b          (w_b_in[B_W-1:0]),
                .i_unsigned_a (w_ua_in),
                .i_unsigned_b (w_ub_in),
                .o_p          (w_z2)
            );

            assign w_z_next = {w_z1, w_z2};
        end else if (MODE_BITS[FRACTURE_BIT] === 1'b0) begin : g_full
            logic [FULL_Z_W-1:0] w_full_a;
            logic [FULL_Z_W-1:0] w_full_b;

            assign w_full_a = {{(FULL_Z_W-FULL_A_W){~w_ua_in & w_opa[FULL_A_W-1]}}, w_opa};
            assign w_full_b = {{(FULL_Z_W-FULL_B_W){~w_ub_in & w_b_in[FULL_B_W-1]}}, w_b_in};
            assign w_z_next = w_full_a * w_full_b;
        end else begin : g_unknown
            assign w_z_next = 'x;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (lreset) begin
            z     <= '0;
            dly_b <= '0;
        end else begin
            z     <= w_z_next;
            dly_b <= b;
        end
    end

endmodule

// File: tb/tb_rs_dsp_mult_regout_model.sv
module tb_rs_dsp_mult_regout_model;

    typedef struct packed {
        logic [19:0] a;
        logic [17:0] b;
        logic [2:0]  fb;
        logic        ua;
        logic        ub;
    } in_t;

    // COEFF_0..3, reserved nibble (non-zero on purpose), FRACTURE
    localparam logic [84:0] MODE_FRAC = {10'd100, 10'h3F0, 10'h200, 10'd511,
                                         10'd4,   10'd6,   10'h3FF, 10'd1,
                                         4'b1010, 1'b1};
    localparam logic [84:0] MODE_FULL = {MODE_FRAC[84:1], 1'b0};

    logic        clk;
    logic        lreset;
    logic [19:0] a;
    logic [17:0] b;
    logic [2:0]  feedback;
    logic        unsigned_a;
    logic        unsigned_b;
    logic [37:0] z_frac, z_full, z_pipe;
    logic [17:0] dly_frac, dly_full, dly_pipe;

    int checks = 0;
    int errors = 0;

    logic [37:0] exp_frac, exp_full, exp_pipe;
    logic [17:0] exp_dly;
    in_t         stg = '0;

    rs_dsp_mult_regout_model #(.MODE_BITS(MODE_FRAC), .INPUT_REG(0)) u_frac (
        .clk(clk), .lreset(lreset), .a(a), .b(b), .feedback(feedback),
        .unsigned_a(unsigned_a), .unsigned_b(unsigned_b), .z(z_frac), .dly_b(dly_frac));

    rs_dsp_mult_regout_model #(.MODE_BITS(MODE_FULL), .INPUT_REG(0)) u_full (
        .clk(clk), .lreset(lreset), .a(a), .b(b), .feedback(feedback),
        .unsigned_a(unsigned_a), .unsigned_b(unsigned_b), .z(z_full), .dly_b(dly_full));

    rs_dsp_mult_regout_model #(.MODE_BITS(MODE_FRAC), .INPUT_REG(1)) u_pipe (
        .clk(clk), .lreset(lreset), .a(a), .b(b), .feedback(feedback),
        .unsigned_a(unsigned_a), .unsigned_b(unsigned_b), .z(z_pipe), .dly_b(dly_pipe));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the decoded operands.
    function automatic logic [37:0] ref_z(input logic [84:0] mode, input in_t v);
        logic [84:0] sh;
        logic [19:0] opa;
        longint      x1, y1, x2, y2, p1, p2, x, y, p;
        logic [63:0] t1, t2, t;
        sh  = mode >> (65 - 20 * int'(v.fb[1:0]));
        opa = v.fb[2] ? sh[19:0] : v.a;
        if (mode[0]) begin
            x1 = v.ua ? longint'(opa[19:10]) : longint'($signed(opa[19:10]));
            x2 = v.ua ? longint'(opa[9:0])   : longint'($signed(opa[9:0]));
            y1 = v.ub ? longint'(v.b[17:9])  : longint'($signed(v.b[17:9]));
            y2 = v.ub ? longint'(v.b[8:0])   : longint'($signed(v.b[8:0]));
            p1 = x1 * y1;
            p2 = x2 * y2;
            t1 = p1;
            t2 = p2;
            return {t1[18:0], t2[18:0]};
        end
        x = v.ua ? longint'(opa) : longint'($signed(opa));
        y = v.ub ? longint'(v.b) : longint'($signed(v.b));
        p = x * y;
        t = p;
        return t[37:0];
    endfunction

    // Apply one cycle of inputs and advance the expected outputs.
    task automatic drive(input logic rst, input in_t v);
        lreset     = rst;
        a          = v.a;
        b          = v.b;
        feedback   = v.fb;
        unsigned_a = v.ua;
        unsigned_b = v.ub;
        @(posedge clk);
        #1;
        exp_frac = rst ? '0 : ref_z(MODE_FRAC, v);
        exp_full = rst ? '0 : ref_z(MODE_FULL, v);
        exp_pipe = rst ? '0 : ref_z(MODE_FRAC, stg);
        stg      = rst ? '0 : v;
        exp_dly  = rst ? '0 : v.b;
    endtask

    function automatic in_t rand_in();
        in_t v;
        v.a  = 20'($urandom);
        v.b  = 18'($urandom);
        v.fb = 3'($urandom);
        v.ua = 1'($urandom);
        v.ub = 1'($urandom);
        return v;
    endfunction

    task automatic test_reset();
        in_t v;
        v = '{a: 20'hABCDE, b: 18'h2BEEF, fb: 3'b001, ua: 1'b1, ub: 1'b0};
        drive(1'b1, v);
        drive(1'b1, v);
        checks++;
        if (z_frac !== 38'd0) begin errors++; $display("FAIL reset_z_frac got %h exp 0", z_frac); end
        checks++;
        if (z_pipe !== 38'd0) begin errors++; $display("FAIL reset_z_pipe got %h exp 0", z_pipe); end
        checks++;
        if (z_full !== 38'd0) begin errors++; $display("FAIL reset_z_full got %h exp 0", z_full); end
        checks++;
        if (dly_frac !== 18'd0) begin errors++; $display("FAIL reset_dly_b got %h exp 0", dly_frac); end
        v = '{a: {10'd3, 10'd5}, b: {9'd7, 9'd2}, fb: 3'b000, ua: 1'b1, ub: 1'b1};
        drive(1'b0, v);
        checks++;
        if (z_frac[37:19] !== 19'd21) begin errors++; $display("FAIL post_reset_z1 got %0d exp 21", z_frac[37:19]); end
        checks++;
        if (z_frac[18:0] !== 19'd10) begin errors++; $display("FAIL post_reset_z2 got %0d exp 10", z_frac[18:0]); end
        checks++;
        if (dly_frac !== {9'd7, 9'd2}) begin errors++; $display("FAIL post_reset_dly_b got %h exp %h", dly_frac, {9'd7, 9'd2}); end
        checks++;
        if (z_pipe !== 38'd0) begin errors++; $display("FAIL post_reset_pipe got %h exp 0", z_pipe); end
    endtask

    task automatic test_signed_lanes();
        in_t v;
        v = '{a: {10'h3FF, 10'h200}, b: {9'h1FF, 9'h0FF}, fb: 3'b000, ua: 1'b0, ub: 1'b0};
        drive(1'b0, v);
        checks++;
        if (z_frac[37:19] !== 19'd1) begin errors++; $display("FAIL signed_z1 got %h exp 1", z_frac[37:19]); end
        checks++;
        if (z_frac[18:0] !== 19'h60200) begin errors++; $display("FAIL signed_z2 got %h exp 60200", z_frac[18:0]); end
    endtask

    task automatic test_mixed_extremes();
        in_t v;
        v = '{a: {10'd1023, 10'd1023}, b: {9'h100, 9'h0FF}, fb: 3'b000, ua: 1'b1, ub: 1'b0};
        drive(1'b0, v);
        checks++;
        if (z_frac[37:19] !== 19'h40100) begin errors++; $display("FAIL mixed_z1 got %h exp 40100", z_frac[37:19]); end
        checks++;
        if (z_frac !== exp_frac) begin errors++; $display("FAIL mixed_z got %h exp %h", z_frac, exp_frac); end
    endtask

    task automatic test_coeff_feedback();
        in_t v;
        v = '{a: 20'h55555, b: {9'd3, 9'd3}, fb: 3'b110, ua: 1'b1, ub: 1'b1};
        drive(1'b0, v);
        checks++;
        if (z_frac[37:19] !== 19'd12) begin errors++; $display("FAIL coeff_z1 got %0d exp 12", z_frac[37:19]); end
        checks++;
        if (z_frac[18:0] !== 19'd18) begin errors++; $display("FAIL coeff_z2 got %0d exp 18", z_frac[18:0]); end
        v = '{a: {10'd9, 10'd11}, b: {9'd3, 9'd3}, fb: 3'b000, ua: 1'b1, ub: 1'b1};
        drive(1'b0, v);
        checks++;
        if (z_frac !== {19'd27, 19'd33}) begin errors++; $display("FAIL coeff_to_a got %h exp %h", z_frac, {19'd27, 19'd33}); end
        checks++;
        if (z_pipe !== {19'd12, 19'd18}) begin errors++; $display("FAIL coeff_pipe got %h exp %h", z_pipe, {19'd12, 19'd18}); end
        for (int i = 0; i < 4; i++) begin
            v = '{a: 20'($urandom), b: 18'($urandom), fb: {1'b1, 2'(i)}, ua: 1'($urandom), ub: 1'($urandom)};
            drive(1'b0, v);
            checks++;
            if (z_frac !== exp_frac) begin errors++; $display("FAIL coeff_idx%0d got %h exp %h", i, z_frac, exp_frac); end
        end
    endtask

    task automatic test_full();
        in_t v;
        logic [37:0] neg1000;
        neg1000 = -38'sd1000;
        v = '{a: 20'hFFFFF, b: 18'd1000, fb: 3'b000, ua: 1'b0, ub: 1'b0};
        drive(1'b0, v);
        checks++;
        if (z_full !== neg1000) begin errors++; $display("FAIL full_neg1000 got %h exp %h", z_full, neg1000); end
        v = '{a: 20'hFFFFF, b: 18'h3FFFF, fb: 3'b000, ua: 1'b1, ub: 1'b1};
        drive(1'b0, v);
        checks++;
        if (z_full !== exp_full) begin errors++; $display("FAIL full_max_unsigned got %h exp %h", z_full, exp_full); end
        v = '{a: 20'h80000, b: 18'h20000, fb: 3'b000, ua: 1'b0, ub: 1'b0};
        drive(1'b0, v);
        checks++;
        if (z_full !== exp_full) begin errors++; $display("FAIL full_min_signed got %h exp %h", z_full, exp_full); end
    endtask

    task automatic test_pipeline_reset();
        in_t v0, v1, v2, v3;
        logic [37:0] want;
        v0 = rand_in();
        v1 = rand_in();
        v0.fb = 3'b000;
        v0.a  = {10'd17, 10'd21};
        v0.b  = {9'd5, 9'd6};
        drive(1'b0, v0);
        want = ref_z(MODE_FRAC, v0);
        drive(1'b0, v1);
        checks++;
        if (z_pipe !== want) begin errors++; $display("FAIL pipe_latency2 got %h exp %h", z_pipe, want); end
        v0 = rand_in();
        v1 = rand_in();
        v2 = rand_in();
        v3 = rand_in();
        drive(1'b0, v0);
        drive(1'b1, v1);
        checks++;
        if (z_pipe !== 38'd0) begin errors++; $display("FAIL pipe_rst_c2 got %h exp 0", z_pipe); end
        drive(1'b0, v2);
        checks++;
        if (z_pipe !== 38'd0) begin errors++; $display("FAIL pipe_rst_c3 got %h exp 0", z_pipe); end
        drive(1'b0, v3);
        want = ref_z(MODE_FRAC, v2);
        checks++;
        if (z_pipe !== want) begin errors++; $display("FAIL pipe_first_valid got %h exp %h", z_pipe, want); end
        checks++;
        if (dly_pipe !== v3.b) begin errors++; $display("FAIL pipe_dly_b got %h exp %h", dly_pipe, v3.b); end
    endtask

    task automatic test_random();
        in_t v;
        logic rst;
        for (int i = 0; i < 300; i++) begin
            v   = rand_in();
            rst = ($urandom_range(0, 19) == 0);
            drive(rst, v);
            checks++;
            if (z_frac !== exp_frac) begin errors++; $display("FAIL rand_frac[%0d] got %h exp %h", i, z_frac, exp_frac); end
            checks++;
            if (z_full !== exp_full) begin errors++; $display("FAIL rand_full[%0d] got %h exp %h", i, z_full, exp_full); end
            checks++;
            if (z_pipe !== exp_pipe) begin errors++; $display("FAIL rand_pipe[%0d] got %h exp %h", i, z_pipe, exp_pipe); end
            checks++;
            if (dly_frac !== exp_dly || dly_pipe !== exp_dly || dly_full !== exp_dly) begin
                errors++;
                $display("FAIL rand_dly_b[%0d] got %h/%h/%h exp %h", i, dly_frac, dly_full, dly_pipe, exp_dly);
            end
        end
    endtask

    initial begin
        lreset     = 1'b1;
        a          = '0;
        b          = '0;
        feedback   = '0;
        unsigned_a = 1'b0;
        unsigned_b = 1'b0;
        test_reset();
        test_signed_lanes();
        test_mixed_extremes();
        test_coeff_feedback();
        test_full();
        test_pipeline_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
